// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: EX/MEM bundle field positions,
// forwarding record layout, FSM state encoding and the reset stack pointer.
package mem_stage_pkg;

    localparam int BUNDLE_W = 106;

    // Flags and branch qualifiers travel with the bundle but are not used here.
    localparam int B_CF  = 105;
    localparam int B_NF  = 104;
    localparam int B_ZF  = 103;
    localparam int B_JMP = 102;
    localparam int B_JZ  = 99;

    // Multi-bit fields, addressed as [LO +: width].
    localparam int B_INPORT_LO = 83;   // 16 bits
    localparam int B_NPC_LO    = 51;   // 32 bits
    localparam int B_RSRC_LO   = 35;   // 16 bits
    localparam int B_ALU_LO    = 19;   // 16 bits
    localparam int B_RSRCA_LO  = 16;   // 3 bits
    localparam int B_RDST_LO   = 13;   // 3 bits

    // Control bits.
    localparam int B_PRVSSTACK = 12;
    localparam int B_PUSH      = 11;
    localparam int B_POP       = 10;
    localparam int B_RET       = 9;
    localparam int B_RTI       = 8;
    localparam int B_LDD       = 7;
    localparam int B_IN        = 6;
    localparam int B_OUT       = 5;
    localparam int B_SCNDITER  = 4;
    localparam int B_CALL      = 3;
    localparam int B_MEMREAD   = 2;
    localparam int B_MEMWRITE  = 1;
    localparam int B_WB        = 0;

    // Forwarding record {WB, Rdst[2:0], result[15:0]}.
    localparam int FWD_W       = 20;
    localparam int FWD_WB      = 19;
    localparam int FWD_RDST_LO = 16;
    localparam int FWD_DATA_LO = 0;

    localparam logic [31:0] SP_INIT_DEFAULT = 32'h000F_FFFE;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SECOND = 2'd1,
        THIRD  = 2'd2
    } memState_t;

    // Which multi-word transfer is in flight.
    typedef enum logic [1:0] {
        OP_CALL = 2'd0,
        OP_RET  = 2'd1,
        OP_RTI  = 2'd2
    } stackOp_t;

endpackage

// File: rtl/memory_stage_stack_pointer.sv
// Stack pointer register: synchronous reset to SP_INIT, signed step
// (-2..+3) applied when enabled, wrapping modulo 2^ADDR_W.
module stack_pointer #(
    parameter int                ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] SP_INIT = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic signed [2:0] step,
    output logic [ADDR_W-1:0] sp
);

    // SP update: reset wins, otherwise add the sign-extended step when enabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            sp <= SP_INIT;
        end else if (en) begin
            sp <= sp + {{(ADDR_W-3){step[2]}}, step};
        end
    end

endmodule

// File: rtl/memory_stage.sv
// Memory stage of the 16-bit RISC pipeline. Performs loads/stores, owns the
// stack pointer and sequences the multi-word CALL/RET/RTI stack transfers.
// Optional build macro SP_BOUNDS_CHK_EN adds a registered stack_fault output
// and suppresses stack ops that would leave the [0, SP_INIT] window.
//
// Flow control: Stall is the only handshake. In is consumed on every cycle
// with Stall=0; while Stall=1 upstream must hold In unchanged and this stage
// works from its own latched copy of the fields it needs.
//
// Stack layout: CALL stores next-PC high half at SP and low half at SP-1, so
// on return the word at SP+1 is the low half and SP+2 the high half; RTI finds
// the saved flags one word further up at SP+3.
module memory_stage
    import mem_stage_pkg::*;
#(
    parameter int                ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] SP_INIT = ADDR_W'(SP_INIT_DEFAULT)
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [105:0]      In,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [15:0]       mem_rdata,
    output logic              Stall,
    output logic [19:0]       Fwd_Mem,
    output logic              wb_en,
    output logic [2:0]        wb_addr,
    output logic [15:0]       wb_data,
    output logic              pc_load,
    output logic [31:0]       pc_value,
    output logic              flags_load,
    output logic [2:0]        flags_value,
`ifdef SP_BOUNDS_CHK_EN
    output logic              stack_fault,
`endif
    output memState_t         dbgState,
    output logic [ADDR_W-1:0] dbgSp
);

    memState_t         state, nextState;
    stackOp_t          opLatch;
    logic [31:0]       npcLatch, pcNext;
    logic [15:0]       aluLatch, firstWord, secondWord;
    logic [2:0]        rdstLatch;
    logic              wbLatch;
    logic [ADDR_W-1:0] sp, addrC;
    logic              spEn;
    logic signed [2:0] spStep;
    logic              stallC, weC, reC, wbC, faultNow;
    logic              captureOp, captureFirst, captureSecond, pcLoadC, flagsLoadC;
    logic [15:0]       wdataC, resultC;
    logic [2:0]        rdstC;

    logic [15:0] aluIn, rsrcIn, inPortIn;
    logic [31:0] npcIn;
    logic [2:0]  rdstIn;
    logic        doRti, doRet, doCall, doPop, doPush;
    logic        unusedBits;

    assign aluIn    = In[B_ALU_LO +: 16];
    assign rsrcIn   = In[B_RSRC_LO +: 16];
    assign inPortIn = In[B_INPORT_LO +: 16];
    assign npcIn    = In[B_NPC_LO +: 32];
    assign rdstIn   = In[B_RDST_LO +: 3];
    assign unusedBits = ^{In[B_CF:B_JZ], In[B_RSRCA_LO +: 3], In[B_PRVSSTACK],
                          In[B_OUT], In[B_SCNDITER]};

    // Stack-op priority RTI > RET > CALL > POP > PUSH.
    assign doRti  = In[B_RTI];
    assign doRet  = In[B_RET]  & ~In[B_RTI];
    assign doCall = In[B_CALL] & ~In[B_RTI] & ~In[B_RET];
    assign doPop  = In[B_POP]  & ~In[B_RTI] & ~In[B_RET] & ~In[B_CALL];
    assign doPush = In[B_PUSH] & ~In[B_RTI] & ~In[B_RET] & ~In[B_CALL] & ~In[B_POP];

`ifdef SP_BOUNDS_CHK_EN
    logic [ADDR_W:0] spWide, spLimit;
    assign spWide  = {1'b0, sp};
    assign spLimit = {1'b0, SP_INIT};
    assign faultNow = (state == IDLE) &&
                      ((doPush && (sp < ADDR_W'(1))) ||
                       (doCall && (sp < ADDR_W'(2))) ||
                       (doPop  && (spWide + (ADDR_W+1)'(1) > spLimit)) ||
                       (doRet  && (spWide + (ADDR_W+1)'(2) > spLimit)) ||
                       (doRti  && (spWide + (ADDR_W+1)'(3) > spLimit)));

    // One-cycle fault pulse for a rejected stack op.
    always_ff @(posedge CLK) begin
        if (Reset) stack_fault <= 1'b0;
        else       stack_fault <= faultNow;
    end
`else
    assign faultNow = 1'b0;
`endif

    stack_pointer #(.ADDR_W(ADDR_W), .SP_INIT(SP_INIT)) u_sp (
        .clk   (CLK),
        .reset (Reset),
        .en    (spEn),
        .step  (spStep),
        .sp    (sp)
    );

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (Reset) state <= IDLE;
        else       state <= nextState;
    end

    // Next state, memory strobes, SP step and the stage result.
    always_comb begin
        nextState     = state;
        stallC        = 1'b0;
        weC           = 1'b0;
        reC           = 1'b0;
        addrC         = '0;
        wdataC        = '0;
        spEn          = 1'b0;
        spStep        = '0;
        resultC       = aluIn;
        rdstC         = rdstIn;
        wbC           = In[B_WB];
        captureOp     = 1'b0;
        captureFirst  = 1'b0;
        captureSecond = 1'b0;
        pcLoadC       = 1'b0;
        flagsLoadC    = 1'b0;
        pcNext        = {secondWord, firstWord};
        case (state)
            IDLE: begin
                if (!faultNow) begin
                    if (doRti || doRet) begin
                        reC = 1'b1; addrC = sp + ADDR_W'(1);
                        captureOp = 1'b1; captureFirst = 1'b1;
                        stallC = 1'b1; nextState = SECOND;
                    end else if (doCall) begin
                        weC = 1'b1; addrC = sp; wdataC = npcIn[31:16];
                        captureOp = 1'b1; stallC = 1'b1; nextState = SECOND;
                    end else if (doPop) begin
                        reC = 1'b1; addrC = sp + ADDR_W'(1); resultC = mem_rdata;
                        spEn = 1'b1; spStep = 3'sd1;
                    end else if (doPush) begin
                        weC = 1'b1; addrC = sp; wdataC = rsrcIn;
                        spEn = 1'b1; spStep = -3'sd1;
                    end else if (In[B_MEMWRITE]) begin
                        weC = 1'b1; addrC = ADDR_W'(aluIn); wdataC = rsrcIn;
                    end else if (In[B_MEMREAD] || In[B_LDD]) begin
                        reC = 1'b1; addrC = ADDR_W'(aluIn); resultC = mem_rdata;
                    end
                end
                if (In[B_IN]) resultC = inPortIn;
            end
            SECOND: begin
                rdstC = rdstLatch; wbC = wbLatch; resultC = aluLatch;
                case (opLatch)
                    OP_CALL: begin
                        weC = 1'b1; addrC = sp - ADDR_W'(1); wdataC = npcLatch[15:0];
                        spEn = 1'b1; spStep = -3'sd2; nextState = IDLE;
                    end
                    OP_RET: begin
                        reC = 1'b1; addrC = sp + ADDR_W'(2);
                        pcLoadC = 1'b1; pcNext = {mem_rdata, firstWord};
                        spEn = 1'b1; spStep = 3'sd2; nextState = IDLE;
                    end
                    default: begin
                        reC = 1'b1; addrC = sp + ADDR_W'(2); captureSecond = 1'b1;
                        stallC = 1'b1; nextState = THIRD;
                    end
                endcase
            end
            THIRD: begin
                rdstC = rdstLatch; wbC = wbLatch; resultC = aluLatch;
                reC = 1'b1; addrC = sp + ADDR_W'(3);
                pcLoadC = 1'b1; flagsLoadC = 1'b1;
                spEn = 1'b1; spStep = 3'sd3; nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Strobes and stall are forced low while reset is held so an aborted
    // sequence cannot commit its pending write.
    assign Stall     = stallC & ~Reset;
    assign mem_we    = weC & ~Reset;
    assign mem_re    = reC & ~Reset;
    assign mem_addr  = addrC;
    assign mem_wdata = wdataC;
    assign Fwd_Mem   = {wbC & ~Stall, rdstC, resultC};
    assign dbgState  = state;
    assign dbgSp     = sp;

    // Capture the fields and stack words a multi-word transfer needs later.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            opLatch    <= OP_CALL;
            npcLatch   <= '0;
            aluLatch   <= '0;
            rdstLatch  <= '0;
            wbLatch    <= 1'b0;
            firstWord  <= '0;
            secondWord <= '0;
        end else begin
            if (captureOp) begin
                opLatch   <= doRti ? OP_RTI : (doRet ? OP_RET : OP_CALL);
                npcLatch  <= npcIn;
                aluLatch  <= aluIn;
                rdstLatch <= rdstIn;
                wbLatch   <= In[B_WB];
            end
            if (captureFirst)  firstWord  <= mem_rdata;
            if (captureSecond) secondWord <= mem_rdata;
        end
    end

    // MEM/WB register plus the PC and flags restore pulses.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            wb_en       <= 1'b0;
            wb_addr     <= '0;
            wb_data     <= '0;
            pc_load     <= 1'b0;
            pc_value    <= '0;
            flags_load  <= 1'b0;
            flags_value <= '0;
        end else begin
            wb_en      <= Fwd_Mem[FWD_WB];
            wb_addr    <= rdstC;
            wb_data    <= resultC;
            pc_load    <= pcLoadC;
            flags_load <= flagsLoadC;
            if (pcLoadC)    pc_value    <= pcNext;
            if (flagsLoadC) flags_value <= mem_rdata[2:0];
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;
    import mem_stage_pkg::*;

    localparam logic [31:0] SP0    = 32'h000F_FFFE;
    localparam logic [12:0] C_PUSH = 13'h0800;
    localparam logic [12:0] C_POP  = 13'h0400;
    localparam logic [12:0] C_RET  = 13'h0200;
    localparam logic [12:0] C_RTI  = 13'h0100;
    localparam logic [12:0] C_LDD  = 13'h0080;
    localparam logic [12:0] C_IN   = 13'h0040;
    localparam logic [12:0] C_CALL = 13'h0008;
    localparam logic [12:0] C_MR   = 13'h0004;
    localparam logic [12:0] C_MW   = 13'h0002;
    localparam logic [12:0] C_WB   = 13'h0001;

    logic         CLK = 1'b0;
    logic         Reset;
    logic [105:0] In;
    logic [31:0]  mem_addr;
    logic [15:0]  mem_wdata, mem_rdata;
    logic         mem_we, mem_re, Stall;
    logic [19:0]  Fwd_Mem;
    logic         wb_en, pc_load, flags_load;
    logic [2:0]   wb_addr, flags_value;
    logic [15:0]  wb_data;
    logic [31:0]  pc_value, dbgSp;
    memState_t    dbgState;

    // Bench data memory, aliased on the low address byte; stack words live at
    // 0xF0..0xFF and load/store traffic below 0x80, so the two never collide.
    logic [15:0] benchMem [0:255];
    assign mem_rdata = benchMem[mem_addr[7:0]];

    int checks = 0;
    int errors = 0;
    logic [47:0] exp_q[$];

    memory_stage dut (
        .CLK(CLK), .Reset(Reset), .In(In),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .Stall(Stall), .Fwd_Mem(Fwd_Mem),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .pc_load(pc_load), .pc_value(pc_value),
        .flags_load(flags_load), .flags_value(flags_value),
        .dbgState(dbgState), .dbgSp(dbgSp)
    );

    // Clock and watchdog.
    always #5 CLK = ~CLK;
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [105:0] mk(input logic [12:0] ctrl, input logic [15:0] alu,
                                        input logic [15:0] rsrc, input logic [15:0] inp,
                                        input logic [31:0] npc, input logic [2:0] rdst);
        return {3'b000, 4'b0000, inp, npc, rsrc, alu, 3'b000, rdst, ctrl};
    endfunction

    // Scoreboard the current cycle's write, then advance one clock and commit it.
    task automatic step();
        logic        pw;
        logic [7:0]  pa;
        logic [15:0] pd;
        logic [47:0] e;
        pw = 1'b0; pa = '0; pd = '0;
        if (mem_we === 1'b1) begin
            pw = 1'b1; pa = mem_addr[7:0]; pd = mem_wdata;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h, required no write",
                         mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== e) begin
                    errors++;
                    $display("FAIL write: got addr %0h data %0h, required addr %0h data %0h",
                             mem_addr, mem_wdata, e[47:16], e[15:0]);
                end
            end
        end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL missing_write: got none, required addr %0h data %0h",
                     exp_q[0][47:16], exp_q[0][15:0]);
            exp_q.delete();
        end
        @(posedge CLK); #1;
        if (pw) benchMem[pa] = pd;
    endtask

    task automatic doReset();
        Reset = 1'b1; In = '0; exp_q.delete();
        repeat (2) begin @(posedge CLK); #1; end
        Reset = 1'b0;
    endtask

    typedef struct {
        logic [12:0] ctrl;
        logic [15:0] alu;
        logic [15:0] rsrc;
        logic [15:0] inp;
        logic [2:0]  rdst;
        logic        expWe;
        logic        expRe;
        logic [31:0] expAddr;
        logic [15:0] expWdata;
        logic [19:0] expFwd;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [15:0] refStack[$];
        logic [15:0] refMem [0:127];
        logic [15:0] alu, rsrc, inp, res;
        logic [2:0]  rdst;
        logic        wb, isRead;
        logic [12:0] ctrl;
        logic [31:0] raddr;
        int          kind;

        for (int i = 0; i < 256; i++) benchMem[i] = '0;

        // Reset state.
        doReset();
        Reset = 1'b1;
        chk("reset_stall", Stall, 0);
        chk("reset_we", mem_we, 0);
        chk("reset_re", mem_re, 0);
        chk("reset_wb_en", wb_en, 0);
        chk("reset_pc_load", pc_load, 0);
        chk("reset_flags_load", flags_load, 0);
        chk("reset_state", dbgState, IDLE);
        chk("reset_sp", dbgSp, SP0);
        Reset = 1'b0;

        // PUSH then POP of the same word.
        In = mk(C_PUSH, 16'h0, 16'hABCD, 16'h0, 32'h0, 3'd0);
        exp_q.push_back({SP0, 16'hABCD});
        #1; chk("push_stall", Stall, 0);
        step();
        chk("push_sp", dbgSp, SP0 - 1);
        In = mk(C_POP | C_WB, 16'h0, 16'h0, 16'h0, 32'h0, 3'd2);
        #1;
        chk("pop_re", mem_re, 1);
        chk("pop_addr", mem_addr, SP0);
        chk("pop_fwd", Fwd_Mem, {1'b1, 3'd2, 16'hABCD});
        step();
        chk("pop_wb", {wb_en, wb_addr, wb_data}, {1'b1, 3'd2, 16'hABCD});
        chk("pop_sp", dbgSp, SP0);

        // CALL then RET restores the same PC.
        doReset();
        In = mk(C_CALL, 16'h0, 16'h0, 16'h0, 32'h0001_2345, 3'd0);
        exp_q.push_back({SP0, 16'h0001});
        #1; chk("call1_stall", Stall, 1);
        step(); #1;
        chk("call2_stall", Stall, 0);
        chk("call2_state", dbgState, SECOND);
        exp_q.push_back({SP0 - 32'd1, 16'h2345});
        step();
        In = '0;
        chk("call_sp", dbgSp, SP0 - 2);
        In = mk(C_RET, 16'h0, 16'h0, 16'h0, 32'h0, 3'd0);
        #1;
        chk("ret1_stall", Stall, 1);
        chk("ret1_re", mem_re, 1);
        chk("ret1_addr", mem_addr, SP0 - 1);
        step(); #1;
        chk("ret2_stall", Stall, 0);
        chk("ret2_addr", mem_addr, SP0);
        chk("ret2_pc_load", pc_load, 0);
        step();
        In = '0;
        chk("ret_pc_load", pc_load, 1);
        chk("ret_pc_value", pc_value, 32'h0001_2345);
        chk("ret_sp", dbgSp, SP0);
        #1; chk("ret_after_stall", Stall, 0);
        step();
        chk("ret_pc_pulse", pc_load, 0);

        // LDD with same-cycle forward and next-cycle writeback.
        benchMem[8'h10] = 16'h5A5A;
        In = mk(C_LDD | C_MR | C_WB, 16'h0010, 16'h0, 16'h0, 32'h0, 3'd3);
        #1;
        chk("ldd_re", mem_re, 1);
        chk("ldd_addr", mem_addr, 32'h10);
        chk("ldd_fwd", Fwd_Mem, {1'b1, 3'd3, 16'h5A5A});
        step();
        In = '0;
        chk("ldd_wb", {wb_en, wb_addr, wb_data}, {1'b1, 3'd3, 16'h5A5A});

        // RTI: stack built by pushes (flags, then hi, then lo).
        doReset();
        for (int i = 0; i < 3; i++) begin
            rsrc = (i == 0) ? 16'h0005 : ((i == 1) ? 16'h0000 : 16'h0040);
            In = mk(C_PUSH, 16'h0, rsrc, 16'h0, 32'h0, 3'd0);
            exp_q.push_back({SP0 - 32'(i), rsrc});
            #1; step();
        end
        In = mk(C_RTI | C_WB, 16'h0099, 16'h0, 16'h0, 32'h0, 3'd4);
        #1;
        chk("rti1_stall", Stall, 1);
        chk("rti1_addr", mem_addr, SP0 - 2);
        chk("rti1_fwd_wb", Fwd_Mem[19], 0);
        step(); #1;
        chk("rti2_stall", Stall, 1);
        chk("rti2_addr", mem_addr, SP0 - 1);
        chk("rti2_state", dbgState, SECOND);
        chk("rti2_wb_en", wb_en, 0);
        step(); #1;
        chk("rti3_stall", Stall, 0);
        chk("rti3_addr", mem_addr, SP0);
        chk("rti3_state", dbgState, THIRD);
        chk("rti3_fwd", Fwd_Mem, {1'b1, 3'd4, 16'h0099});
        step();
        In = '0;
        chk("rti_pc_load", pc_load, 1);
        chk("rti_pc_value", pc_value, 32'h0000_0040);
        chk("rti_flags_load", flags_load, 1);
        chk("rti_flags_value", flags_value, 3'b101);
        chk("rti_sp", dbgSp, SP0);
        chk("rti_wb_en", wb_en, 1);

        // Reset while CALL is in its second cycle.
        doReset();
        In = mk(C_CALL, 16'h0, 16'h0, 16'h0, 32'hCAFE_0123, 3'd0);
        exp_q.push_back({SP0, 16'hCAFE});
        #1; step();
        Reset = 1'b1;
        #1;
        chk("rstmid_we", mem_we, 0);
        chk("rstmid_stall", Stall, 0);
        step();
        Reset = 1'b0; In = '0;
        #1;
        chk("rstmid_state", dbgState, IDLE);
        chk("rstmid_sp", dbgSp, SP0);
        chk("rstmid_stall_after", Stall, 0);
        step();
        chk("rstmid_pc_load", pc_load, 0);

        // Table of single-cycle operations.
        doReset();
        vecs[0] = '{C_WB,               16'h1234, 16'h0,    16'h0,    3'd5, 1'b0, 1'b0, 32'h0,  16'h0,    {1'b1, 3'd5, 16'h1234}};
        vecs[1] = '{C_MW,               16'h0020, 16'hBEEF, 16'h0,    3'd0, 1'b1, 1'b0, 32'h20, 16'hBEEF, {1'b0, 3'd0, 16'h0020}};
        vecs[2] = '{C_LDD | C_MR | C_WB, 16'h0020, 16'h0,    16'h0,    3'd1, 1'b0, 1'b1, 32'h20, 16'h0,    {1'b1, 3'd1, 16'hBEEF}};
        vecs[3] = '{C_IN | C_WB,        16'h0042, 16'h0,    16'h7777, 3'd6, 1'b0, 1'b0, 32'h0,  16'h0,    {1'b1, 3'd6, 16'h7777}};
        vecs[4] = '{C_MR | C_MW | C_WB, 16'h0030, 16'h1111, 16'h0,    3'd2, 1'b1, 1'b0, 32'h30, 16'h1111, {1'b1, 3'd2, 16'h0030}};
        vecs[5] = '{C_MR | C_WB,        16'h0030, 16'h0,    16'h0,    3'd7, 1'b0, 1'b1, 32'h30, 16'h0,    {1'b1, 3'd7, 16'h1111}};
        vecs[6] = '{C_POP | C_PUSH | C_WB, 16'h0055, 16'h2222, 16'h0, 3'd3, 1'b0, 1'b1, SP0 + 32'd1, 16'h0, {1'b1, 3'd3, 16'h0000}};
        for (int v = 0; v < 7; v++) begin
            In = mk(vecs[v].ctrl, vecs[v].alu, vecs[v].rsrc, vecs[v].inp, 32'h0, vecs[v].rdst);
            if (vecs[v].expWe) exp_q.push_back({vecs[v].expAddr, vecs[v].expWdata});
            #1;
            chk($sformatf("vec%0d_fwd", v), Fwd_Mem, vecs[v].expFwd);
            chk($sformatf("vec%0d_re", v), mem_re, vecs[v].expRe);
            chk($sformatf("vec%0d_stall", v), Stall, 0);
            if (vecs[v].expRe) chk($sformatf("vec%0d_raddr", v), mem_addr, vecs[v].expAddr);
            step();
            chk($sformatf("vec%0d_wb", v), {wb_en, wb_addr, wb_data}, vecs[v].expFwd);
        end
        In = '0;

        // Randomized single-cycle traffic against a stack/memory model.
        doReset();
        for (int i = 0; i < 256; i++) benchMem[i] = '0;
        for (int i = 0; i < 128; i++) refMem[i] = '0;
        refStack.delete();
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 5);
            alu  = 16'($urandom_range(0, 127));
            rsrc = 16'($urandom);
            inp  = 16'($urandom);
            rdst = 3'($urandom_range(0, 7));
            wb   = 1'($urandom_range(0, 1));
            if (kind == 0 && refStack.size() >= 12) kind = 5;
            if (kind == 1 && refStack.size() == 0) kind = 5;
            res = alu; isRead = 1'b0; raddr = '0; ctrl = '0;
            case (kind)
                0: begin
                    ctrl = C_PUSH;
                    exp_q.push_back({SP0 - 32'(refStack.size()), rsrc});
                    refStack.push_back(rsrc);
                end
                1: begin
                    ctrl = C_POP; isRead = 1'b1;
                    raddr = SP0 - 32'(refStack.size()) + 32'd1;
                    res = refStack.pop_back();
                end
                2: begin
                    ctrl = C_MW;
                    exp_q.push_back({32'(alu), rsrc});
                    refMem[alu[6:0]] = rsrc;
                end
                3: begin
                    ctrl = C_LDD | C_MR; isRead = 1'b1;
                    raddr = 32'(alu); res = refMem[alu[6:0]];
                end
                4: begin
                    ctrl = C_IN; res = inp;
                end
                default: ctrl = '0;
            endcase
            if (wb) ctrl = ctrl | C_WB;
            In = mk(ctrl, alu, rsrc, inp, 32'h0, rdst);
            #1;
            chk("rnd_fwd", Fwd_Mem, {wb, rdst, res});
            if (isRead) chk("rnd_raddr", mem_addr, raddr);
            step();
            chk("rnd_wb", {wb_en, wb_addr, wb_data}, {wb, rdst, res});
            chk("rnd_sp", dbgSp, SP0 - 32'(refStack.size()));
        end
        In = '0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
